// File: rtl/snn_pkg.sv
// Shared types and helpers for the network run scheduler.
// The state enum and the run window length live here so the top and any
// future siblings agree on encoding and timing.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Number of enabled network cycles in one classification run.
  function automatic int run_len(input int width);
    return 2 ** (width + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping around, and returns it as a one-hot grant (all zero if no request).
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  int   idx;
  logic found;

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/network_run_scheduler.sv
// Time-shares one spiking network between NREQ requesters. Each granted
// request gets a network reset cycle, then a fixed window of enabled cycles
// in which the first output spike is timestamped, then a held result.
// Optional build macro NETWORK_EARLY_STOP_EN ends the run window on the
// cycle after the first spike instead of running the full window.
module network_run_scheduler
  import snn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7,
  parameter int NREQ   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*HEIGHT-1:0]   req_pixels,
  output logic [NREQ-1:0]          req_ready,
  output logic                     net_rst,
  output logic                     net_en,
  output logic [HEIGHT-1:0]        net_pixels,
  input  logic                     net_spike,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     res_spike,
  output logic [WIDTH:0]           res_cycles
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(run_len(WIDTH) - 1);

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [HEIGHT-1:0] pixels_reg;
  logic [IDW-1:0]   id_reg;
  logic             spike_reg;
  logic [CW-1:0]    cycles_reg;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic [HEIGHT-1:0] grant_pixels;
  logic              any_req;
  logic              first_spike;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  assign any_req     = |req_valid;
  assign first_spike = (state_reg == RUN) && net_spike && !spike_reg;

  // Encode the one-hot grant and select the matching pixel slice.
  always_comb begin
    grant_idx    = '0;
    grant_pixels = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx    = IDW'(i);
        grant_pixels = req_pixels[i*HEIGHT +: HEIGHT];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; new requests are only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (any_req) state_next = CLEAR;
      CLEAR:  state_next = RUN;
      RUN: begin
        if (cnt_reg == CNT_LAST) state_next = REPORT;
`ifdef NETWORK_EARLY_STOP_EN
        if (first_spike) state_next = REPORT;
`endif
      end
      REPORT: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: grant capture, run counter, first-spike timestamp, pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      pixels_reg <= '0;
      id_reg     <= '0;
      spike_reg  <= 1'b0;
      cycles_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            pixels_reg <= grant_pixels;
            id_reg     <= grant_idx;
            spike_reg  <= 1'b0;
            cycles_reg <= '0;
          end
        end
        CLEAR: cnt_reg <= '0;
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (first_spike) begin
            spike_reg  <= 1'b1;
            cycles_reg <= cnt_reg;
          end
        end
        REPORT: begin
          if (res_ready) ptr_reg <= (int'(id_reg) == NREQ - 1) ? '0 : id_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE && !rst) ? grant : '0;
  assign net_rst    = rst || (state_reg == CLEAR);
  assign net_en     = (state_reg == RUN);
  assign net_pixels = pixels_reg;
  assign res_valid  = (state_reg == REPORT);
  assign res_id     = id_reg;
  assign res_spike  = spike_reg;
  assign res_cycles = cycles_reg;

endmodule
